// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants for the EX-stage ALU control and the
// iterative multiply/divide unit.
//   - ALU operation codes driven to the main ALU
//   - R-type funct field values and main-control select values
//   - mul/div FSM state type
//   - is_hilo_grp(): funct belongs to the mul/div/HI-LO group
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;

    localparam logic [2:0] SEL_RTYPE = 3'b000;
    localparam logic [2:0] SEL_ADD   = 3'b001;
    localparam logic [2:0] SEL_SUB   = 3'b010;
    localparam logic [2:0] SEL_AND   = 3'b011;
    localparam logic [2:0] SEL_OR    = 3'b100;
    localparam logic [2:0] SEL_SLT   = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_e;

    // 0100xx: mfhi/mthi/mflo/mtlo, 0110xx: mult/multu/div/divu
    function automatic logic is_hilo_grp(input logic [5:0] f);
        return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
    endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_if.sv
// alu_muldiv_ctrl_if: EX-stage bundle between the main control unit and
// the ALU control / mul-div block.
//   master: drives valid, sel, funct, rs_val, rt_val; reads the results
//   slave : the ALU control block (alu_op, illegal, md_busy, stall,
//           hilo_rdata, hi, lo)
interface alu_muldiv_ctrl_if #(parameter int WIDTH = 32);

    logic             valid;
    logic [2:0]       sel;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [3:0]       alu_op;
    logic             illegal;
    logic             md_busy;
    logic             stall;
    logic [WIDTH-1:0] hilo_rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid, sel, funct, rs_val, rt_val,
        input  alu_op, illegal, md_busy, stall, hilo_rdata, hi, lo
    );

    modport slave (
        input  valid, sel, funct, rs_val, rt_val,
        output alu_op, illegal, md_busy, stall, hilo_rdata, hi, lo
    );

endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: iterative WIDTH-bit multiply / restoring divide.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin an operation (only honoured in IDLE)
//   is_signed       : signed operands (mult/div)
//   is_div          : divide instead of multiply
//   a, b            : rs (multiplicand/dividend), rt (multiplier/divisor)
//   busy            : registered, high from the start edge through FIX
//   done            : FIX state; res_hi/res_lo are valid this cycle
//   res_hi, res_lo  : sign-corrected result (HI:LO product, or rem:quot)
// Signed operations run on magnitudes; signs are applied in FIX.
module muldiv_core
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state;
    logic [CW-1:0]    cnt;
    // acc: product high half / partial remainder
    // sreg: multiplier shifting out, product low half / dividend -> quotient
    // opnd: multiplicand / divisor
    logic [WIDTH-1:0] acc, sreg, opnd;
    logic             neg_q;     // negate product or quotient
    logic             neg_r;     // negate remainder (dividend sign)
    logic             dz;        // divide by zero: quotient forced to all ones
    logic             div_op;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     msum, shifted, diff;
    logic [2*WIDTH-1:0] prod, prod_c;
    logic [WIDTH-1:0]   quo_c, rem_c;

    always_comb begin
        mag_a   = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b   = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        msum    = {1'b0, acc} + {1'b0, (sreg[0] ? opnd : {WIDTH{1'b0}})};
        shifted = {acc, sreg[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        prod    = {acc, sreg};
        prod_c  = neg_q ? (~prod + 1'b1) : prod;
        quo_c   = dz ? {WIDTH{1'b1}} : (neg_q ? (~sreg + 1'b1) : sreg);
        rem_c   = neg_r ? (~acc + 1'b1) : acc;
        res_hi  = div_op ? rem_c : prod_c[2*WIDTH-1:WIDTH];
        res_lo  = div_op ? quo_c : prod_c[WIDTH-1:0];
    end

    assign done = (state == FIX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            sreg   <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            div_op <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        sreg   <= is_div ? mag_a : mag_b;
                        opnd   <= is_div ? mag_b : mag_a;
                        neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= is_signed && a[WIDTH-1];
                        dz     <= is_div && (b == '0);
                        div_op <= is_div;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= is_div ? DIV : MUL;
                    end
                end
                MUL: begin
                    {acc, sreg} <= {msum, sreg[WIDTH-1:1]};
                    cnt         <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                DIV: begin
                    // restore by keeping the shifted remainder when the trial subtract borrows
                    acc  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    sreg <= {sreg[WIDTH-2:0], ~diff[WIDTH]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: EX-stage ALU control with multiply/divide and HI/LO.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of alu_muldiv_ctrl_if
//     in : valid, sel, funct, rs_val, rt_val
//     out: alu_op, illegal, stall, hilo_rdata (combinational)
//          md_busy, hi, lo (registered)
// Decode, stall and the HI/LO write port live here; the iterative
// datapath lives in muldiv_core.
module alu_muldiv_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_muldiv_ctrl_if.slave  bus
);

    logic             rtype, grp, accept, start, is_signed, is_div;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH-1:0] hi_q, lo_q;

    assign rtype = (bus.sel == SEL_RTYPE);
    assign grp   = is_hilo_grp(bus.funct);
    // a HI/LO-group instruction is only taken when the unit is free
    assign accept    = bus.valid && rtype && !md_busy;
    assign start     = accept && (bus.funct == F_MULT || bus.funct == F_MULTU ||
                                  bus.funct == F_DIV  || bus.funct == F_DIVU);
    assign is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    assign is_div    = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);

    always_comb begin
        bus.alu_op  = ALU_ADD;
        bus.illegal = 1'b0;
        case (bus.sel)
            SEL_RTYPE: begin
                case (bus.funct)
                    F_ADD, F_ADDU: bus.alu_op = ALU_ADD;
                    F_SUB, F_SUBU: bus.alu_op = ALU_SUB;
                    F_AND:         bus.alu_op = ALU_AND;
                    F_OR:          bus.alu_op = ALU_OR;
                    F_XOR:         bus.alu_op = ALU_XOR;
                    F_NOR:         bus.alu_op = ALU_NOR;
                    F_SLT:         bus.alu_op = ALU_SLT;
                    default:       bus.illegal = bus.valid && !grp;
                endcase
            end
            SEL_ADD: bus.alu_op = ALU_ADD;
            SEL_SUB: bus.alu_op = ALU_SUB;
            SEL_AND: bus.alu_op = ALU_AND;
            SEL_OR:  bus.alu_op = ALU_OR;
            SEL_SLT: bus.alu_op = ALU_SLT;
            default: bus.alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        bus.hilo_rdata = '0;
        if (rtype && bus.funct == F_MFHI) bus.hilo_rdata = hi_q;
        if (rtype && bus.funct == F_MFLO) bus.hilo_rdata = lo_q;
    end

    assign bus.stall   = bus.valid && rtype && grp && md_busy;
    assign bus.md_busy = md_busy;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

    // done and an accepted mthi/mtlo never coincide: busy is high in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_done) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (accept && bus.funct == F_MTHI) begin
            hi_q <= bus.rs_val;
        end else if (accept && bus.funct == F_MTLO) begin
            lo_q <= bus.rs_val;
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .is_div    (is_div),
        .a         (bus.rs_val),
        .b         (bus.rt_val),
        .busy      (md_busy),
        .done      (md_done),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: directed + randomized bench for alu_muldiv_ctrl at
// WIDTH=32, with a plain-arithmetic reference model for decode and mul/div.
module tb_alu_muldiv_ctrl;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   ncmp  = 0;
    int   nfail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_muldiv_ctrl_if #(.WIDTH(W)) bus ();

    alu_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // {illegal, alu_op}
    function automatic logic [4:0] dec_model(input logic v, input logic [2:0] s, input logic [5:0] f);
        logic [3:0] op;
        logic       ill;
        op  = 4'b0010;
        ill = 1'b0;
        if (s == 3'd0) begin
            casez (f)
                6'b10000?: op = 4'b0010;
                6'b10001?: op = 4'b0110;
                6'b100100: op = 4'b0000;
                6'b100101: op = 4'b0001;
                6'b100110: op = 4'b0011;
                6'b100111: op = 4'b1100;
                6'b101010: op = 4'b0111;
                6'b0110??, 6'b0100??: op = 4'b0010;
                default:   ill = v;
            endcase
        end else begin
            case (s)
                3'd1: op = 4'b0010;
                3'd2: op = 4'b0110;
                3'd3: op = 4'b0000;
                3'd4: op = 4'b0001;
                3'd5: op = 4'b0111;
                default: op = 4'b0010;
            endcase
        end
        return {ill, op};
    endfunction

    // {HI, LO}
    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int     sa, sb;
        sa = a;
        sb = b;
        case (f)
            6'b011000: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            6'b011001: return {32'd0, a} * {32'd0, b};
            6'b011010: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.md_busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic issue_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] e;
        int          n;
        tick();
        bus.valid = 1'b1; bus.sel = 3'd0; bus.funct = f; bus.rs_val = a; bus.rt_val = b;
        #1;
        check({tag, ".stall_idle"}, 64'(bus.stall), 64'd0);
        tick();
        // operands after the start edge must not matter
        bus.valid = 1'b0; bus.rs_val = $urandom; bus.rt_val = $urandom;
        wait_idle(n);
        e = md_model(f, a, b);
        m_hi = e[63:32];
        m_lo = e[31:0];
        check({tag, ".busy_cyc"}, 64'(n), 64'd33);
        check({tag, ".hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    initial begin
        logic [4:0]  d;
        logic [63:0] e;
        int          n;
        logic [5:0]  fsel [4];

        fsel[0] = 6'b011000; fsel[1] = 6'b011001; fsel[2] = 6'b011010; fsel[3] = 6'b011011;

        rst_n = 1'b0;
        bus.valid = 1'b0; bus.sel = 3'd0; bus.funct = 6'd0; bus.rs_val = '0; bus.rt_val = '0;
        #2;
        check("rst.hi", 64'(bus.hi), 64'd0);
        check("rst.lo", 64'(bus.lo), 64'd0);
        check("rst.busy", 64'(bus.md_busy), 64'd0);

        // decode sweep runs under reset so mul/div functs cannot start
        for (int f = 0; f < 64; f++) begin
            bus.valid = 1'b1; bus.sel = 3'd0; bus.funct = 6'(f);
            #1;
            d = dec_model(1'b1, 3'd0, 6'(f));
            check($sformatf("dec.f%02h.op", f), 64'(bus.alu_op), 64'(d[3:0]));
            check($sformatf("dec.f%02h.ill", f), 64'(bus.illegal), 64'(d[4]));
        end
        for (int s = 1; s < 8; s++) begin
            bus.sel = 3'(s); bus.funct = 6'($urandom);
            #1;
            d = dec_model(1'b1, 3'(s), bus.funct);
            check($sformatf("dec.sel%0d.op", s), 64'(bus.alu_op), 64'(d[3:0]));
            check($sformatf("dec.sel%0d.ill", s), 64'(bus.illegal), 64'(d[4]));
        end
        bus.sel = 3'd0; bus.funct = 6'b100111; #1;
        check("dec.nor", 64'(bus.alu_op), 64'hC);
        bus.funct = 6'b000101; #1;
        check("dec.bad.ill", 64'(bus.illegal), 64'd1);
        bus.valid = 1'b0; #1;
        check("dec.bad.novalid", 64'(bus.illegal), 64'd0);
        for (int i = 0; i < 40; i++) begin
            bus.valid = 1'($urandom); bus.sel = 3'($urandom); bus.funct = 6'($urandom);
            #1;
            d = dec_model(bus.valid, bus.sel, bus.funct);
            check("dec.rand", {59'd0, bus.illegal, bus.alu_op}, 64'(d));
        end
        bus.valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // directed mul/div
        issue_md(6'b011000, 32'd7, 32'hFFFF_FFFD, "mult7x-3");
        check("mult7x-3.lit", {64'(bus.hi) << 32} | 64'(bus.lo), 64'hFFFF_FFFF_FFFF_FFEB);
        issue_md(6'b011001, 32'hFFFF_FFFF, 32'd2, "multu");
        check("multu.lit", {64'(bus.hi) << 32} | 64'(bus.lo), 64'h0000_0001_FFFF_FFFE);
        issue_md(6'b011011, 32'd100, 32'd7, "divu100/7");
        check("divu.lit", {64'(bus.hi) << 32} | 64'(bus.lo), {32'd2, 32'd14});
        issue_md(6'b011010, 32'hFFFF_FFF9, 32'd2, "div-7/2");
        check("div.lit", {64'(bus.hi) << 32} | 64'(bus.lo), 64'hFFFF_FFFF_FFFF_FFFD);
        issue_md(6'b011010, 32'd5, 32'd0, "div5/0");
        issue_md(6'b011010, 32'hFFFF_FFFB, 32'd0, "div-5/0");
        issue_md(6'b011011, 32'd5, 32'd0, "divu5/0");
        issue_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, "divmin/-1");
        issue_md(6'b011000, 32'h8000_0000, 32'h8000_0000, "multmin");

        // dependent mflo: add in the first busy cycle, then mflo stalls 32 cycles
        tick();
        bus.valid = 1'b1; bus.sel = 3'd0; bus.funct = 6'b011000;
        bus.rs_val = 32'h1234_5678; bus.rt_val = 32'hFFFF_FFFE;
        tick();
        bus.funct = 6'b100000; bus.rs_val = $urandom; bus.rt_val = $urandom;
        #1;
        check("add_busy.stall", 64'(bus.stall), 64'd0);
        tick();
        bus.funct = 6'b010010;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            tick();
            n++;
        end
        e = md_model(6'b011000, 32'h1234_5678, 32'hFFFF_FFFE);
        m_hi = e[63:32]; m_lo = e[31:0];
        check("mflo.stall_cyc", 64'(n), 64'd32);
        check("mflo.rdata", 64'(bus.hilo_rdata), 64'(m_lo));
        bus.valid = 1'b0;

        // mthi / mtlo
        tick();
        bus.valid = 1'b1; bus.sel = 3'd0; bus.funct = 6'b010001; bus.rs_val = 32'hDEAD;
        #1;
        check("mthi.old_hi", 64'(bus.hi), 64'(m_hi));
        check("mthi.stall", 64'(bus.stall), 64'd0);
        tick();
        bus.funct = 6'b010000;
        #1;
        m_hi = 32'hDEAD;
        check("mfhi.rdata", 64'(bus.hilo_rdata), 64'(m_hi));
        bus.funct = 6'b010011; bus.rs_val = 32'hBEEF;
        tick();
        bus.funct = 6'b010010;
        #1;
        m_lo = 32'hBEEF;
        check("mflo2.rdata", 64'(bus.hilo_rdata), 64'(m_lo));
        check("mtlo.hi_kept", 64'(bus.hi), 64'(m_hi));
        bus.funct = 6'b100000;
        #1;
        check("add.rdata0", 64'(bus.hilo_rdata), 64'd0);
        bus.valid = 1'b0;

        // second mult while busy is held off and dropped
        tick();
        bus.valid = 1'b1; bus.sel = 3'd0; bus.funct = 6'b011000;
        bus.rs_val = 32'hFFFE_1DC0; bus.rt_val = 32'd789;
        tick();
        bus.funct = 6'b011001; bus.rs_val = 32'hFFFF_FFFF; bus.rt_val = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("mult2.stall", 64'(bus.stall), 64'd1);
            @(posedge clk);
            #1;
        end
        bus.valid = 1'b0;
        wait_idle(n);
        e = md_model(6'b011000, 32'hFFFE_1DC0, 32'd789);
        m_hi = e[63:32]; m_lo = e[31:0];
        check("mult2.busy_cyc", 64'(n + 5), 64'd33);
        check("mult2.hi", 64'(bus.hi), 64'(m_hi));
        check("mult2.lo", 64'(bus.lo), 64'(m_lo));
        tick();
        check("mult2.not_taken", 64'(bus.md_busy), 64'd0);

        // async reset in the middle of a divide
        tick();
        bus.valid = 1'b1; bus.sel = 3'd0; bus.funct = 6'b011010;
        bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
        tick();
        bus.valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort.busy_before", 64'(bus.md_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        check("abort.busy", 64'(bus.md_busy), 64'd0);
        check("abort.hi", 64'(bus.hi), 64'd0);
        check("abort.lo", 64'(bus.lo), 64'd0);
        tick();
        rst_n = 1'b1;
        issue_md(6'b011010, 32'hFFFF_FF9C, 32'd7, "div_after_rst");

        // randomized mul/div against the model
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) b = -b;
            issue_md(fsel[$urandom_range(0, 3)], a, b, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
